// File: rtl/veggie_pkg.sv
// Shared types and constants for the veggie game scheduler.
package veggie_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } game_state_t;

  localparam logic [15:0] KEY_START = 16'h0028;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  localparam logic [9:0] VX_NEG2 = 10'h3FE;
  localparam logic [9:0] VX_NEG1 = 10'h3FF;
  localparam logic [9:0] VX_POS1 = 10'h001;
  localparam logic [9:0] VX_POS2 = 10'h002;

  localparam int unsigned VY_BASE = 5;

  function automatic logic [9:0] vx_lookup(input logic [1:0] sel);
    logic [9:0] vx;
    case (sel)
      2'b00:   vx = VX_NEG2;
      2'b01:   vx = VX_NEG1;
      2'b10:   vx = VX_POS1;
      default: vx = VX_POS2;
    endcase
    return vx;
  endfunction

endpackage

// File: rtl/veggie_scheduler_if.sv
// Link between the scheduler and the projectile mover array.
interface veggie_scheduler_if #(
  parameter int NUM_SLOTS = 4
);
  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  logic [NUM_SLOTS-1:0] slot_sliced;
  logic [NUM_SLOTS-1:0] slot_done;
  logic [NUM_SLOTS-1:0] slot_active;
  logic                 spawn_valid;
  logic [SLOT_W-1:0]    spawn_slot;
  logic [9:0]           spawn_x;
  logic [9:0]           spawn_vx;
  logic [9:0]           spawn_vy;

  modport master (
    input  slot_sliced, slot_done,
    output slot_active, spawn_valid, spawn_slot, spawn_x, spawn_vx, spawn_vy
  );

  modport slave (
    output slot_sliced, slot_done,
    input  slot_active, spawn_valid, spawn_slot, spawn_x, spawn_vx, spawn_vy
  );
endinterface

// File: rtl/veggie_scheduler_lfsr16.sv
// 16-bit right-shifting Galois LFSR; advances on every non-reset frame.
module lfsr16
  import veggie_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        frame_clk,
  input  logic        Reset,
  output logic [15:0] value
);

  always_ff @(posedge frame_clk) begin
    if (Reset) value <= SEED;
    else       value <= {1'b0, value[15:1]} ^ (value[0] ? LFSR_MASK : 16'h0000);
  end

endmodule

// File: rtl/veggie_scheduler.sv
// Game flow, slot bookkeeping and launch scheduling for the projectile movers.
//   state | meaning
//   IDLE  | after reset, all outputs zero, waiting for Enter
//   PLAY  | retiring sliced/missed slots, launching on the spawn timer
//   OVER  | miss limit reached, score frozen, waiting for Enter
module veggie_scheduler
  import veggie_pkg::*;
#(
  parameter int unsigned   NUM_SLOTS    = 4,
  parameter int unsigned   SPAWN_PERIOD = 90,
  parameter int unsigned   MAX_MISSES   = 3,
  parameter logic [15:0]   LFSR_SEED    = 16'hACE1,
  parameter int unsigned   X_MIN        = 64,
  parameter int unsigned   X_MAX        = 575
) (
  input  logic                frame_clk,
  input  logic                Reset,
  input  logic [15:0]         CodeKey,
  veggie_scheduler_if.master  bus,
  output logic [15:0]         score,
  output logic [1:0]          misses,
  output logic [1:0]          game_state
);

  localparam int SLOT_W  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int TIMER_W = $clog2(SPAWN_PERIOD + 1);

  game_state_t          state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 key_q;
  logic [15:0]          score_q, score_d;
  logic [1:0]           misses_q, misses_d;
  logic [NUM_SLOTS-1:0] active_q, active_d;
  logic                 valid_q, valid_d;
  logic [SLOT_W-1:0]    slot_q, slot_d;
  logic [9:0]           x_q, x_d, vx_q, vx_d, vy_q, vy_d;

  logic [15:0]          lfsr_val;
  logic                 key_is_start, start_evt;
  logic [NUM_SLOTS-1:0] sliced_hit, done_hit;
  logic [16:0]          score_sum;
  logic [3:0]           miss_sum;
  logic                 free_found;
  logic [SLOT_W-1:0]    free_idx;
  logic [10:0]          x_sum;
  logic                 unused_lfsr;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .value     (lfsr_val)
  );

  assign unused_lfsr  = ^{lfsr_val[15:14], lfsr_val[9]};
  assign key_is_start = (CodeKey == KEY_START);
  assign start_evt    = key_is_start && !key_q;

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      key_q    <= 1'b0;
      score_q  <= '0;
      misses_q <= '0;
      active_q <= '0;
      valid_q  <= 1'b0;
      slot_q   <= '0;
      x_q      <= '0;
      vx_q     <= '0;
      vy_q     <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      key_q    <= key_is_start;
      score_q  <= score_d;
      misses_q <= misses_d;
      active_q <= active_d;
      valid_q  <= valid_d;
      slot_q   <= slot_d;
      x_q      <= x_d;
      vx_q     <= vx_d;
      vy_q     <= vy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    score_d    = score_q;
    misses_d   = misses_q;
    active_d   = active_q;
    valid_d    = 1'b0;
    slot_d     = slot_q;
    x_d        = x_q;
    vx_d       = vx_q;
    vy_d       = vy_q;

    // A slice on the same slot masks a simultaneous miss.
    sliced_hit = bus.slot_sliced & active_q;
    done_hit   = bus.slot_done & active_q & ~bus.slot_sliced;
    score_sum  = {1'b0, score_q} + 17'($countones(sliced_hit));
    miss_sum   = {2'b00, misses_q} + 4'($countones(done_hit));

    // Free slot search uses the registered mask, so same-cycle retires wait a frame.
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!active_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = SLOT_W'(i);
      end
    end

    x_sum = 11'(X_MIN) + {2'b00, lfsr_val[8:0]};

    case (state_q)
      IDLE, OVER: begin
        if (start_evt) begin
          state_d  = PLAY;
          score_d  = '0;
          misses_d = '0;
          active_d = '0;
          timer_d  = '0;
        end
      end
      PLAY: begin
        score_d  = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        active_d = active_q & ~(sliced_hit | done_hit);
        if (miss_sum >= 4'(MAX_MISSES)) begin
          misses_d = 2'(MAX_MISSES);
          state_d  = OVER;
          active_d = '0;
        end else begin
          misses_d = miss_sum[1:0];
          if (timer_q != '0) begin
            timer_d = timer_q - 1'b1;
          end else if (free_found) begin
            valid_d            = 1'b1;
            slot_d             = free_idx;
            active_d[free_idx] = 1'b1;
            timer_d            = TIMER_W'(SPAWN_PERIOD - 1);
            x_d  = (x_sum > 11'(X_MAX)) ? 10'(X_MAX) : x_sum[9:0];
            vx_d = vx_lookup(lfsr_val[11:10]);
            vy_d = 10'd0 - (10'(VY_BASE) + {8'b0, lfsr_val[13:12]});
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign score           = score_q;
  assign misses          = misses_q;
  assign game_state      = state_q;
  assign bus.slot_active = active_q;
  assign bus.spawn_valid = valid_q;
  assign bus.spawn_slot  = slot_q;
  assign bus.spawn_x     = x_q;
  assign bus.spawn_vx    = vx_q;
  assign bus.spawn_vy    = vy_q;

endmodule

// File: tb/tb_veggie_scheduler.sv
// Randomized scoreboard bench for veggie_scheduler against a frame-level game model.
module tb_veggie_scheduler;

  localparam int NS     = 2;
  localparam int PERIOD = 4;
  localparam int MAXM   = 3;
  localparam int NCYC   = 4000;

  logic        clk;
  logic        rst;
  logic [15:0] key;
  logic [15:0] score;
  logic [1:0]  misses;
  logic [1:0]  game_state;

  veggie_scheduler_if #(.NUM_SLOTS(NS)) bus ();

  veggie_scheduler #(
    .NUM_SLOTS(NS), .SPAWN_PERIOD(PERIOD), .MAX_MISSES(MAXM),
    .LFSR_SEED(16'hACE1), .X_MIN(64), .X_MAX(575)
  ) dut (
    .frame_clk  (clk),
    .Reset      (rst),
    .CodeKey    (key),
    .bus        (bus),
    .score      (score),
    .misses     (misses),
    .game_state (game_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int slot; int x; int vx; int vy; } spawn_t;
  typedef struct { int state; int score; int misses; int active; bit valid; } stat_t;

  spawn_t spawn_q[$];
  stat_t  stat_q[$];

  int checks = 0;
  int errors = 0;
  int n_launch = 0;

  // Game model: state 0 idle, 1 play, 2 over; m_wait = frames until next launch attempt.
  int          m_state, m_score, m_misses, m_wait;
  bit          m_fly[NS];
  logic [15:0] m_lfsr;
  bit          m_prev;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int to10(input int v);
    return v & 32'h3FF;
  endfunction

  task automatic model_step(input bit r, input logic [15:0] k, input logic [1:0] sl, input logic [1:0] dn);
    stat_t       st;
    spawn_t      sp;
    logic [15:0] l;
    bit          start, launched;
    bit          was_fly[NS];
    int          nm, sel;
    launched = 0;
    if (r) begin
      m_state = 0; m_score = 0; m_misses = 0; m_wait = 0;
      foreach (m_fly[i]) m_fly[i] = 0;
      m_lfsr = 16'hACE1; m_prev = 0;
    end else begin
      l      = m_lfsr;
      start  = (k == 16'h28) && !m_prev;
      m_prev = (k == 16'h28);
      m_lfsr = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
      if (m_state != 1) begin
        if (start) begin
          m_state = 1; m_score = 0; m_misses = 0; m_wait = 0;
          foreach (m_fly[i]) m_fly[i] = 0;
        end
      end else begin
        was_fly = m_fly;
        nm = m_misses;
        for (int i = 0; i < NS; i++) begin
          if (m_fly[i]) begin
            if (sl[i]) begin
              if (m_score < 65535) m_score++;
              m_fly[i] = 0;
            end else if (dn[i]) begin
              nm++;
              m_fly[i] = 0;
            end
          end
        end
        if (nm >= MAXM) begin
          m_misses = MAXM; m_state = 2;
          foreach (m_fly[i]) m_fly[i] = 0;
        end else begin
          m_misses = nm;
          if (m_wait > 0) m_wait--;
          else begin
            for (int i = 0; i < NS; i++) begin
              if (!was_fly[i] && !launched) begin
                launched = 1;
                m_fly[i] = 1;
                m_wait   = PERIOD - 1;
                sp.slot  = i;
                sp.x     = 64 + int'(l % 512);
                if (sp.x > 575) sp.x = 575;
                sel = int'((l >> 10) & 3);
                sp.vx = to10((sel == 0) ? -2 : (sel == 1) ? -1 : (sel == 2) ? 1 : 2);
                sp.vy = to10(-(5 + int'((l >> 12) & 3)));
                spawn_q.push_back(sp);
                n_launch++;
              end
            end
          end
        end
      end
    end
    st.state  = m_state;
    st.score  = m_score;
    st.misses = m_misses;
    st.active = 0;
    for (int i = 0; i < NS; i++) if (m_fly[i]) st.active |= (1 << i);
    st.valid  = launched;
    stat_q.push_back(st);
  endtask

  // Monitor: one expected status per edge; launch fields popped when the DUT strobes.
  initial begin
    stat_t  st;
    spawn_t sp;
    forever begin
      @(posedge clk);
      #1;
      if (stat_q.size() != 0) begin
        st = stat_q.pop_front();
        check("game_state",  int'(game_state),        st.state);
        check("score",       int'(score),             st.score);
        check("misses",      int'(misses),            st.misses);
        check("slot_active", int'(bus.slot_active),   st.active);
        check("spawn_valid", int'(bus.spawn_valid),   int'(st.valid));
        if (bus.spawn_valid === 1'b1) begin
          if (spawn_q.size() == 0) begin
            check("spawn_unexpected", 1, 0);
          end else begin
            sp = spawn_q.pop_front();
            check("spawn_slot", int'(bus.spawn_slot), sp.slot);
            check("spawn_x",    int'(bus.spawn_x),    sp.x);
            check("spawn_vx",   int'(bus.spawn_vx),   sp.vx);
            check("spawn_vy",   int'(bus.spawn_vy),   sp.vy);
          end
        end
      end
    end
  end

  // Driver: directed start-up, then randomized play with one reset aimed at a launch.
  initial begin
    bit want_rst_launch;
    bit any_free;
    rst = 1'b1;
    key = 16'h0;
    bus.slot_sliced = '0;
    bus.slot_done   = '0;
    want_rst_launch = 0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      if (cyc > 0) @(negedge clk);
      bus.slot_sliced = '0;
      bus.slot_done   = '0;
      if (cyc < 3) begin
        rst = 1'b1; key = 16'h0;
      end else if (cyc < 5) begin
        rst = 1'b0; key = 16'h0;
      end else if (cyc < 15) begin
        key = 16'h28;
      end else if (cyc < 40) begin
        key = 16'h0;
        if (cyc == 30) bus.slot_sliced = 2'b01;
      end else begin
        if (cyc == 2000) want_rst_launch = 1;
        any_free = 0;
        for (int i = 0; i < NS; i++) if (!m_fly[i]) any_free = 1;
        if ($urandom_range(0, 24) == 0)
          key = (key == 16'h28) ? 16'h0 : (($urandom_range(0, 5) == 0) ? 16'h29 : 16'h28);
        for (int i = 0; i < NS; i++) begin
          bus.slot_sliced[i] = ($urandom_range(0, 9) == 0);
          bus.slot_done[i]   = ($urandom_range(0, 19) == 0);
        end
        if ($urandom_range(0, 29) == 0) bus.slot_done = bus.slot_done | bus.slot_sliced;
        rst = ($urandom_range(0, 599) == 0);
        if (want_rst_launch && m_state == 1 && m_wait == 0 && any_free) begin
          bus.slot_sliced = '0;
          bus.slot_done   = '0;
          rst = 1'b1;
          want_rst_launch = 0;
        end
      end
      model_step(rst, key, bus.slot_sliced, bus.slot_done);
    end
    @(posedge clk);
    #2;
    check("spawn_queue_drained", spawn_q.size(), 0);
    check("launches_seen", int'(n_launch > 20), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
